// File: rtl/amber_stg_ex.sv
// Amber EX stage: GP ALU plus trap-on-overflow arithmetic, optional TRAP_CAUSE_EN adds ow_trap_cause.
// Latency 1 cycle: every output is registered from the inputs sampled at the previous edge.
// Backpressure: iw_stall holds all registers, iw_flush turns the cycle into a bubble.
module amber_stg_ex #(
  parameter int                DATA_W      = 24,
  parameter int                ADDR_W      = 48,
  parameter logic [ADDR_W-1:0] TRAP_VECTOR = 48'h0000_0000_0100
) (
  input  logic              iw_clk,
  input  logic              iw_rst_n,
  input  logic [ADDR_W-1:0] iw_pc,
  input  logic [DATA_W-1:0] iw_instr,
  input  logic [7:0]        iw_opc,
  input  logic              iw_sgn_en,
  input  logic              iw_imm_en,
  input  logic [11:0]       iw_imm12_val,
  input  logic [3:0]        iw_tgt_gp,
  input  logic              iw_tgt_gp_we,
  input  logic [DATA_W-1:0] iw_tgt_gp_val,
  input  logic [DATA_W-1:0] iw_src_gp_val,
  input  logic              iw_flush,
  input  logic              iw_stall,
  output logic [ADDR_W-1:0] ow_pc,
  output logic [DATA_W-1:0] ow_instr,
  output logic [7:0]        ow_opc,
  output logic [3:0]        ow_tgt_gp,
  output logic              ow_tgt_gp_we,
  output logic [DATA_W-1:0] ow_result,
  output logic [3:0]        ow_flags,
  output logic              ow_branch_taken,
  output logic [ADDR_W-1:0] ow_branch_pc
`ifdef TRAP_CAUSE_EN
  ,
  output logic [2:0]        ow_trap_cause
`endif
);

  localparam logic [7:0] OPC_NOP    = 8'h00;
  localparam logic [7:0] OPC_MOV    = 8'h01;
  localparam logic [7:0] OPC_ADDUR  = 8'h02;
  localparam logic [7:0] OPC_SUBUR  = 8'h03;
  localparam logic [7:0] OPC_ANDUR  = 8'h04;
  localparam logic [7:0] OPC_ORUR   = 8'h05;
  localparam logic [7:0] OPC_XORUR  = 8'h06;
  localparam logic [7:0] OPC_SHLUR  = 8'h07;
  localparam logic [7:0] OPC_SHRUR  = 8'h08;
  localparam logic [7:0] OPC_SHRSR  = 8'h09;
  localparam logic [7:0] OPC_ADDSV  = 8'h0A;
  localparam logic [7:0] OPC_SUBSV  = 8'h0B;
  localparam logic [7:0] OPC_NEGSV  = 8'h0C;
  localparam logic [7:0] OPC_SHRSRV = 8'h0D;

  localparam int                SH_W    = $clog2(DATA_W);
  localparam int                MSB     = DATA_W - 1;
  localparam logic [DATA_W-1:0] SH_LIM  = DATA_W'(DATA_W);
  localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  assign imm_ext = iw_sgn_en ? {{(DATA_W-12){iw_imm12_val[11]}}, iw_imm12_val}
                             : {{(DATA_W-12){1'b0}}, iw_imm12_val};
  assign op_a    = iw_tgt_gp_val;
  assign op_b    = iw_imm_en ? imm_ext : iw_src_gp_val;

  // One extra bit on each datapath holds carry/borrow or the last bit shifted out.
  logic [DATA_W:0] add_w;
  logic [DATA_W:0] sub_w;
  logic [DATA_W:0] neg_w;
  logic [DATA_W:0] shl_w;
  logic [DATA_W:0] shr_w;
  logic [DATA_W:0] sra_w;
  logic            add_ovf;
  logic            sub_ovf;
  logic            neg_ovf;
  logic            big_sh;
  logic [SH_W-1:0] shamt;
  logic [SH_W-1:0] sra_amt;

  assign add_w   = {1'b0, op_a} + {1'b0, op_b};
  assign sub_w   = {1'b0, op_a} - {1'b0, op_b};
  assign neg_w   = {(DATA_W+1){1'b0}} - {1'b0, op_a};
  assign add_ovf = (op_a[MSB] == op_b[MSB]) && (add_w[MSB] != op_a[MSB]);
  assign sub_ovf = (op_a[MSB] != op_b[MSB]) && (sub_w[MSB] != op_a[MSB]);
  assign neg_ovf = (op_a == NEG_MIN);

  // Range check uses the whole operand so large counts never alias into the 5-bit shamt.
  assign big_sh  = (op_b >= SH_LIM);
  assign shamt   = op_b[SH_W-1:0];
  assign sra_amt = big_sh ? SH_W'(DATA_W-1) : shamt;
  assign shl_w   = {1'b0, op_a} << shamt;
  assign shr_w   = {op_a, 1'b0} >> shamt;
  assign sra_w   = $signed({op_a, 1'b0}) >>> sra_amt;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;
  logic              is_op;
  logic              trap;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    is_op   = 1'b1;
    trap    = 1'b0;
    case (iw_opc)
      OPC_MOV:   alu_res = op_b;
      OPC_ADDUR, OPC_ADDSV: begin
        alu_res = add_w[DATA_W-1:0];
        alu_c   = add_w[DATA_W];
        alu_v   = add_ovf;
        trap    = (iw_opc == OPC_ADDSV) && add_ovf;
      end
      OPC_SUBUR, OPC_SUBSV: begin
        alu_res = sub_w[DATA_W-1:0];
        alu_c   = sub_w[DATA_W];
        alu_v   = sub_ovf;
        trap    = (iw_opc == OPC_SUBSV) && sub_ovf;
      end
      OPC_NEGSV: begin
        alu_res = neg_w[DATA_W-1:0];
        alu_c   = neg_w[DATA_W];
        alu_v   = neg_ovf;
        trap    = neg_ovf;
      end
      OPC_ANDUR: alu_res = op_a & op_b;
      OPC_ORUR:  alu_res = op_a | op_b;
      OPC_XORUR: alu_res = op_a ^ op_b;
      OPC_SHLUR: begin
        alu_res = big_sh ? '0 : shl_w[DATA_W-1:0];
        alu_c   = big_sh ? 1'b0 : shl_w[DATA_W];
      end
      OPC_SHRUR: begin
        alu_res = big_sh ? '0 : shr_w[DATA_W:1];
        alu_c   = big_sh ? 1'b0 : shr_w[0];
      end
      OPC_SHRSR, OPC_SHRSRV: begin
        alu_res = sra_w[DATA_W:1];
        alu_c   = sra_w[0];
        if ((iw_opc == OPC_SHRSRV) && big_sh) begin
          alu_res = '0;
          trap    = 1'b1;
        end
      end
      default:   is_op = 1'b0;
    endcase
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      ow_pc           <= '0;
      ow_instr        <= '0;
      ow_opc          <= OPC_NOP;
      ow_tgt_gp       <= '0;
      ow_tgt_gp_we    <= 1'b0;
      ow_result       <= '0;
      ow_flags        <= '0;
      ow_branch_taken <= 1'b0;
      ow_branch_pc    <= '0;
    end else if (iw_stall) begin
      ow_pc           <= ow_pc;
    end else if (iw_flush) begin
      // Flags are left alone: a bubble is not an executed instruction.
      ow_pc           <= iw_pc;
      ow_instr        <= iw_instr;
      ow_opc          <= OPC_NOP;
      ow_tgt_gp       <= iw_tgt_gp;
      ow_tgt_gp_we    <= 1'b0;
      ow_result       <= '0;
      ow_branch_taken <= 1'b0;
      ow_branch_pc    <= '0;
    end else begin
      ow_pc           <= iw_pc;
      ow_instr        <= iw_instr;
      ow_opc          <= iw_opc;
      ow_tgt_gp       <= iw_tgt_gp;
      ow_tgt_gp_we    <= is_op && iw_tgt_gp_we && !trap;
      ow_result       <= alu_res;
      ow_branch_taken <= trap;
      ow_branch_pc    <= trap ? TRAP_VECTOR : '0;
      if (is_op) begin
        ow_flags <= {(alu_res == '0), alu_res[MSB], alu_c, alu_v};
      end
    end
  end

`ifdef TRAP_CAUSE_EN
  logic [2:0] cause_nxt;

  always_comb begin
    cause_nxt = 3'd0;
    if (trap) begin
      case (iw_opc)
        OPC_ADDSV: cause_nxt = 3'd1;
        OPC_SUBSV: cause_nxt = 3'd2;
        OPC_NEGSV: cause_nxt = 3'd3;
        default:   cause_nxt = 3'd4;
      endcase
    end
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      ow_trap_cause <= 3'd0;
    end else if (!iw_stall) begin
      ow_trap_cause <= iw_flush ? 3'd0 : cause_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_amber_stg_ex.sv
// Bench for amber_stg_ex: directed trap scenarios plus randomized ops against a behavioural model.
module tb_amber_stg_ex;
  localparam logic [47:0] TV = 48'h0000_0000_0100;
  localparam logic [7:0] NOP = 8'h00, MOV = 8'h01, ADDUR = 8'h02, SUBUR = 8'h03, ANDUR = 8'h04,
                         ORUR = 8'h05, XORUR = 8'h06, SHLUR = 8'h07, SHRUR = 8'h08, SHRSR = 8'h09,
                         ADDSV = 8'h0A, SUBSV = 8'h0B, NEGSV = 8'h0C, SHRSRV = 8'h0D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] iw_pc;
  logic [23:0] iw_instr;
  logic [7:0]  iw_opc;
  logic        iw_sgn_en, iw_imm_en;
  logic [11:0] iw_imm12_val;
  logic [3:0]  iw_tgt_gp;
  logic        iw_tgt_gp_we;
  logic [23:0] iw_tgt_gp_val, iw_src_gp_val;
  logic        iw_flush, iw_stall;
  logic [47:0] ow_pc, ow_branch_pc;
  logic [23:0] ow_instr, ow_result;
  logic [7:0]  ow_opc;
  logic [3:0]  ow_tgt_gp, ow_flags;
  logic        ow_tgt_gp_we, ow_branch_taken;

  amber_stg_ex dut (
    .iw_clk(clk), .iw_rst_n(rst_n), .iw_pc(iw_pc), .iw_instr(iw_instr), .iw_opc(iw_opc),
    .iw_sgn_en(iw_sgn_en), .iw_imm_en(iw_imm_en), .iw_imm12_val(iw_imm12_val),
    .iw_tgt_gp(iw_tgt_gp), .iw_tgt_gp_we(iw_tgt_gp_we), .iw_tgt_gp_val(iw_tgt_gp_val),
    .iw_src_gp_val(iw_src_gp_val), .iw_flush(iw_flush), .iw_stall(iw_stall),
    .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_opc(ow_opc), .ow_tgt_gp(ow_tgt_gp),
    .ow_tgt_gp_we(ow_tgt_gp_we), .ow_result(ow_result), .ow_flags(ow_flags),
    .ow_branch_taken(ow_branch_taken), .ow_branch_pc(ow_branch_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected registered outputs
  logic [47:0] e_pc, e_bpc;
  logic [23:0] e_instr, e_res;
  logic [7:0]  e_opc;
  logic [3:0]  e_tgt, e_flags;
  logic        e_we, e_bt;

  // Reference semantics in plain integer arithmetic (signed values as int, 2^24 wraparound).
  task automatic ref_exec(input logic [7:0] opc, input logic [23:0] a, input logic [23:0] b,
                          output logic [23:0] res, output logic c, output logic v,
                          output logic trap, output logic valid);
    int ia, ib, sa, sb, s, t, k;
    longint lt;
    ia = int'(a);
    ib = int'(b);
    sa = a[23] ? ia - 16777216 : ia;
    sb = b[23] ? ib - 16777216 : ib;
    res = 24'h0; c = 1'b0; v = 1'b0; trap = 1'b0; valid = 1'b1;
    case (opc)
      MOV: res = b;
      ADDUR, ADDSV: begin
        t = ia + ib; res = t[23:0]; c = (t >= 16777216);
        s = sa + sb; v = (s > 8388607) || (s < -8388608);
        trap = (opc == ADDSV) && v;
      end
      SUBUR, SUBSV: begin
        t = ia - ib + 16777216; res = t[23:0]; c = (ia < ib);
        s = sa - sb; v = (s > 8388607) || (s < -8388608);
        trap = (opc == SUBSV) && v;
      end
      NEGSV: begin
        t = 16777216 - ia; res = t[23:0]; c = (ia != 0);
        v = (-sa > 8388607); trap = v;
      end
      ANDUR: res = a & b;
      ORUR:  res = a | b;
      XORUR: res = a ^ b;
      SHLUR: if (ib < 24) begin
        lt = longint'(ia) * (longint'(1) << ib); res = lt[23:0]; c = lt[24];
      end
      SHRUR: if (ib < 24) begin
        res = 24'(ia / (1 << ib)); c = (ib > 0) ? ((ia >> (ib - 1)) & 1) != 0 : 1'b0;
      end
      SHRSR, SHRSRV: begin
        k = (ib >= 24) ? 23 : ib;
        t = sa >>> k; res = t[23:0];
        c = (k > 0) ? ((ia >> (k - 1)) & 1) != 0 : 1'b0;
        if (opc == SHRSRV && ib >= 24) begin trap = 1'b1; res = 24'h0; end
      end
      default: valid = 1'b0;
    endcase
  endtask

  // One clock: predict the registered state from the current inputs, then advance to edge+1.
  task automatic step();
    logic [23:0] b, r;
    logic c, v, t, ok;
    b = iw_imm_en ? ((iw_sgn_en && iw_imm12_val[11]) ? {12'hFFF, iw_imm12_val} : {12'h000, iw_imm12_val})
                  : iw_src_gp_val;
    ref_exec(iw_opc, iw_tgt_gp_val, b, r, c, v, t, ok);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      e_pc = '0; e_instr = '0; e_opc = NOP; e_tgt = '0; e_we = 0; e_res = '0;
      e_flags = '0; e_bt = 0; e_bpc = '0;
    end else if (iw_stall) begin
      e_pc = e_pc;
    end else begin
      e_pc = iw_pc; e_instr = iw_instr; e_tgt = iw_tgt_gp;
      if (iw_flush) begin
        e_opc = NOP; e_we = 0; e_res = '0; e_bt = 0; e_bpc = '0;
      end else begin
        e_opc = iw_opc; e_we = ok && iw_tgt_gp_we && !t; e_res = r;
        e_bt = t; e_bpc = t ? TV : '0;
        if (ok) e_flags = {r == 24'h0, r[23], c, v};
      end
    end
  endtask

  task automatic set_op(input logic [7:0] opc, input logic [23:0] a, input logic [23:0] b);
    iw_opc = opc; iw_tgt_gp_val = a; iw_src_gp_val = b; iw_imm_en = 0; iw_sgn_en = 0;
    iw_imm12_val = 12'($urandom); iw_tgt_gp_we = 1; iw_stall = 0; iw_flush = 0;
    iw_pc = {16'h0, $urandom}; iw_instr = 24'($urandom); iw_tgt_gp = 4'($urandom);
  endtask

  function automatic logic [23:0] rnd24();
    case ($urandom_range(0, 6))
      0: return 24'h7FFFFF;
      1: return 24'h800000;
      2: return 24'($urandom_range(0, 30));
      3: return 24'hFFFFFF;
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 0;
    set_op(NOP, 24'h0, 24'h0);
    step(); step();
    checks++;
    if ({ow_pc, ow_instr, ow_opc, ow_tgt_gp, ow_tgt_gp_we, ow_result, ow_flags, ow_branch_taken, ow_branch_pc} !== '0) begin
      errors++; $display("FAIL reset_state got pc=%h res=%h opc=%h bt=%b flags=%h exp all zero",
                         ow_pc, ow_result, ow_opc, ow_branch_taken, ow_flags);
    end
    rst_n = 1;
  endtask

  task automatic test_traps();
    set_op(ADDSV, 24'h7FFFFF, 24'h000001); step();
    checks++; if (ow_branch_taken !== 1'b1 || ow_branch_pc !== TV) begin errors++;
      $display("FAIL addsv_trap got bt=%b bpc=%h exp 1 %h", ow_branch_taken, ow_branch_pc, TV); end
    checks++; if (ow_tgt_gp_we !== 1'b0 || ow_result !== 24'h800000 || ow_flags !== 4'b0101) begin errors++;
      $display("FAIL addsv_we_res got we=%b res=%h flags=%b exp 0 800000 0101", ow_tgt_gp_we, ow_result, ow_flags); end
    set_op(SUBSV, 24'h800000, 24'h000001); step();
    checks++; if (ow_branch_taken !== 1'b1 || ow_tgt_gp_we !== 1'b0 || ow_result !== 24'h7FFFFF) begin errors++;
      $display("FAIL subsv_trap got bt=%b we=%b res=%h exp 1 0 7fffff", ow_branch_taken, ow_tgt_gp_we, ow_result); end
    set_op(NEGSV, 24'h800000, 24'h0); step();
    checks++; if (ow_branch_taken !== 1'b1 || ow_tgt_gp_we !== 1'b0) begin errors++;
      $display("FAIL negsv_trap got bt=%b we=%b exp 1 0", ow_branch_taken, ow_tgt_gp_we); end
    set_op(NEGSV, 24'h000005, 24'h0); step();
    checks++; if (ow_branch_taken !== 1'b0 || ow_tgt_gp_we !== 1'b1 || ow_result !== 24'hFFFFFB || ow_branch_pc !== 48'h0) begin errors++;
      $display("FAIL negsv_ok got bt=%b we=%b res=%h exp 0 1 fffffb", ow_branch_taken, ow_tgt_gp_we, ow_result); end
    set_op(SHRSRV, 24'h0000FF, 24'd24); step();
    checks++; if (ow_branch_taken !== 1'b1 || ow_tgt_gp_we !== 1'b0 || ow_result !== 24'h0) begin errors++;
      $display("FAIL shrsrv_trap got bt=%b we=%b res=%h exp 1 0 0", ow_branch_taken, ow_tgt_gp_we, ow_result); end
    set_op(SHRSRV, 24'h800002, 24'd1); step();
    checks++; if (ow_branch_taken !== 1'b0 || ow_result !== 24'hC00001) begin errors++;
      $display("FAIL shrsrv_ok got bt=%b res=%h exp 0 c00001", ow_branch_taken, ow_result); end
  endtask

  task automatic test_unsigned();
    set_op(ADDUR, 24'hFFFFFF, 24'h123456);
    iw_imm_en = 1; iw_sgn_en = 0; iw_imm12_val = 12'h001; step();
    checks++; if (ow_result !== 24'h0 || ow_flags !== 4'b1010 || ow_branch_taken !== 1'b0) begin errors++;
      $display("FAIL addur_imm got res=%h flags=%b bt=%b exp 0 1010 0", ow_result, ow_flags, ow_branch_taken); end
    set_op(ADDUR, 24'h000010, 24'h0);
    iw_imm_en = 1; iw_sgn_en = 1; iw_imm12_val = 12'hFFF; step();
    checks++; if (ow_result !== 24'h00000F) begin errors++;
      $display("FAIL addur_sext got res=%h exp 00000f", ow_result); end
    set_op(SHLUR, 24'hABCDEF, 24'd24); step();
    checks++; if (ow_result !== 24'h0 || ow_tgt_gp_we !== 1'b1) begin errors++;
      $display("FAIL shlur_24 got res=%h we=%b exp 0 1", ow_result, ow_tgt_gp_we); end
    set_op(NOP, 24'h123456, 24'h1); step();
    checks++; if (ow_tgt_gp_we !== 1'b0 || ow_opc !== NOP) begin errors++;
      $display("FAIL nop_we got we=%b opc=%h exp 0 00", ow_tgt_gp_we, ow_opc); end
  endtask

  task automatic test_stall_flush();
    set_op(ADDSV, 24'h7FFFFF, 24'h000001); step();
    for (int i = 0; i < 3; i++) begin
      set_op(MOV, 24'h0, 24'h000042); iw_stall = 1; iw_flush = (i == 1); step();
      checks++; if (ow_branch_taken !== 1'b1 || ow_tgt_gp_we !== 1'b0 || ow_result !== 24'h800000 || ow_branch_pc !== TV) begin
        errors++; $display("FAIL stall_hold cyc=%0d got bt=%b we=%b res=%h exp 1 0 800000", i, ow_branch_taken, ow_tgt_gp_we, ow_result); end
    end
    set_op(ADDSV, 24'h7FFFFF, 24'h000001); iw_flush = 1; step();
    checks++; if (ow_branch_taken !== 1'b0 || ow_tgt_gp_we !== 1'b0 || ow_opc !== NOP || ow_result !== 24'h0) begin errors++;
      $display("FAIL flush got bt=%b we=%b opc=%h res=%h exp 0 0 00 0", ow_branch_taken, ow_tgt_gp_we, ow_opc, ow_result); end
    checks++; if (ow_pc !== e_pc || ow_instr !== e_instr) begin errors++;
      $display("FAIL flush_pc got pc=%h instr=%h exp %h %h", ow_pc, ow_instr, e_pc, e_instr); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] got;
    set_op(ADDSV, 24'h7FFFFF, 24'h000001); step(); got[0] = ow_branch_taken;
    set_op(SUBSV, 24'h800000, 24'h000001); step(); got[1] = ow_branch_taken;
    set_op(MOV, 24'h0, 24'h000007);        step(); got[2] = ow_branch_taken;
    checks++; if (got !== 3'b011 || ow_tgt_gp_we !== 1'b1 || ow_result !== 24'h000007) begin errors++;
      $display("FAIL back_to_back got bt_seq=%b we=%b res=%h exp 011 1 000007", got, ow_tgt_gp_we, ow_result); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_op(8'($urandom_range(0, 15)), rnd24(), rnd24());
      iw_imm_en = ($urandom_range(0, 3) == 0); iw_sgn_en = $urandom_range(0, 1);
      iw_tgt_gp_we = ($urandom_range(0, 7) != 0);
      iw_stall = ($urandom_range(0, 9) == 0); iw_flush = ($urandom_range(0, 9) == 0);
      step();
      checks++; if (ow_result !== e_res || ow_flags !== e_flags) begin errors++;
        $display("FAIL rnd_alu i=%0d opc=%h got res=%h flags=%b exp res=%h flags=%b", i, ow_opc, ow_result, ow_flags, e_res, e_flags); end
      checks++; if (ow_tgt_gp_we !== e_we || ow_branch_taken !== e_bt || ow_branch_pc !== e_bpc) begin errors++;
        $display("FAIL rnd_ctl i=%0d got we=%b bt=%b bpc=%h exp we=%b bt=%b bpc=%h", i, ow_tgt_gp_we, ow_branch_taken, ow_branch_pc, e_we, e_bt, e_bpc); end
      checks++; if (ow_pc !== e_pc || ow_instr !== e_instr || ow_opc !== e_opc || ow_tgt_gp !== e_tgt) begin errors++;
        $display("FAIL rnd_pass i=%0d got pc=%h opc=%h tgt=%h exp pc=%h opc=%h tgt=%h", i, ow_pc, ow_opc, ow_tgt_gp, e_pc, e_opc, e_tgt); end
    end
  endtask

  task automatic test_async_reset();
    set_op(ADDSV, 24'h7FFFFF, 24'h000001); step();
    #2 rst_n = 0;
    #1;
    checks++; if (ow_branch_taken !== 1'b0 || ow_result !== 24'h0 || ow_pc !== 48'h0 || ow_flags !== 4'h0 || ow_branch_pc !== 48'h0) begin
      errors++; $display("FAIL async_reset got bt=%b res=%h pc=%h flags=%b exp all zero", ow_branch_taken, ow_result, ow_pc, ow_flags); end
    e_pc = '0; e_instr = '0; e_opc = NOP; e_tgt = '0; e_we = 0; e_res = '0; e_flags = '0; e_bt = 0; e_bpc = '0;
    @(negedge clk);
    rst_n = 1;
    set_op(MOV, 24'h0, 24'h000099); step();
    checks++; if (ow_result !== 24'h000099 || ow_tgt_gp_we !== 1'b1) begin errors++;
      $display("FAIL post_reset got res=%h we=%b exp 000099 1", ow_result, ow_tgt_gp_we); end
  endtask

  initial begin
    rst_n = 0;
    set_op(NOP, 24'h0, 24'h0);
    test_reset();
    test_traps();
    test_unsigned();
    test_stall_flush();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/amber_stg_ex.md
Name: amber_stg_ex

Overview:
Execute stage of the Amber 24-bit pipeline, reduced to the GP ALU subset and opclass-2 trapping arithmetic. It sits between register read and memory/writeback. It computes a GP result from the target value (A) and either the source value or an immediate (B), then registers it into the EX/MEM latch. Signed "v" (trap-on-overflow) variants redirect fetch to a trap vector and suppress the GP write.

Parameters:
DATA_W, 24, GP data width (ops are defined for 24; other values unsupported)
ADDR_W, 48, PC/address width
TRAP_VECTOR, 48'h0000_0000_0100, branch target on any trap

Ports:
iw_clk  in  1  clock, rising edge
iw_rst_n  in  1  reset, asynchronous, active-low
iw_pc  in  ADDR_W  PC of the instruction in EX
iw_instr  in  DATA_W  raw instruction word (passed through)
iw_opc  in  8  decoded opcode, values from the shared opcode header
iw_sgn_en  in  1  sign-extend the immediate when 1
iw_imm_en  in  1  B = immediate instead of iw_src_gp_val
iw_imm12_val  in  12  immediate field
iw_tgt_gp  in  4  destination GP index
iw_tgt_gp_we  in  1  decoder write-enable request
iw_tgt_gp_val  in  DATA_W  operand A (current target value)
iw_src_gp_val  in  DATA_W  operand B source
iw_flush  in  1  convert this cycle into a bubble
iw_stall  in  1  hold all outputs
ow_pc, ow_instr, ow_opc, ow_tgt_gp  out  as inputs  registered pass-through
ow_tgt_gp_we  out  1  registered GP write-enable (0 on trap)
ow_result  out  DATA_W  registered ALU result
ow_flags  out  4  registered {Z,N,C,V}
ow_branch_taken  out  1  registered redirect request (trap)
ow_branch_pc  out  ADDR_W  registered redirect target

Behaviour:
- Everything is computed combinationally and captured on the rising edge. Latency is 1 cycle: outputs reflect the inputs sampled at the previous edge.
- Reset (async, iw_rst_n=0): all outputs 0, ow_opc = OPC_NOP encoding.
- Priority: reset > stall > flush > normal.
  - Stall: all registers hold.
  - Flush: we=0, branch_taken=0, result=0, opc=NOP; pc and instr still latched.
- Operand B: iw_imm_en ? ext(imm12) : iw_src_gp_val. ext is sign-extension if iw_sgn_en, zero-extension otherwise.
- Ops (A = tgt value, result written to tgt):
  - NOP: we forced 0.
  - MOV: B.
  - ADDur/SUBur: A±B mod 2^24, C = carry/borrow.
  - ANDur/ORur/XORur: bitwise.
  - SHLur: A<<B[4:0]; count ≥24 gives 0.
  - SHRur: logical right shift; count ≥24 gives 0.
  - SHRsr: arithmetic right shift by min(B,23) sign-fill; count ≥24 gives all copies of A[23].
  - ADDsv/SUBsv: signed A±B.
  - NEGsv: 0−A.
  - SHRsrv: same as SHRsr.
- Flags: Z = result==0, N = result[23], C per add/sub/shift-out, V = signed overflow. Flags are updated for every non-NOP, non-flushed op, including trapped ones.
- Trap conditions, checked for v-variants only:
  - ADDsv: A and B same sign and result sign differs.
  - SUBsv: A and B differ in sign and result sign differs from A.
  - NEGsv: A == 24'h800000.
  - SHRsrv: B ≥ 24, unsigned compare over the full 24 bits.
- On trap: ow_branch_taken=1, ow_branch_pc=TRAP_VECTOR, ow_tgt_gp_we=0. ow_result is still the wrapped arithmetic value, or 0 for SHRsrv.
- No trap: ow_branch_taken=0, ow_branch_pc=0, ow_tgt_gp_we = iw_tgt_gp_we (except NOP).
- Unknown opcode: treated as NOP.
- The trap flag is single-cycle per instruction. Back-to-back traps each assert branch_taken for their own cycle.

Optional Feature:
TRAP_CAUSE_EN:
- Defined: adds output ow_trap_cause [2:0], registered with the other outputs. Values: 0 none, 1 add overflow, 2 sub overflow, 3 neg overflow, 4 shift range. Cleared by reset and flush.
- Not defined: the port is absent; behaviour is otherwise identical.

Test Plan:
- ADDsv A=7FFFFF, B=000001 → branch_taken=1, branch_pc=TRAP_VECTOR, tgt_gp_we=0, V=1.
- SUBsv A=800000, B=000001 → trap, we=0. NEGsv A=800000 → trap, we=0. NEGsv A=000005 → no trap, result FFFFFB.
- SHRsrv A=0000FF, B=24 → trap, we=0. SHRsrv A=800002, B=1 → no trap, result C00001.
- ADDur A=FFFFFF, imm12=001, sgn_en=0, imm_en=1 → result 000000, Z=1, C=1, no trap. SHLur B=24 → result 0.
- Stall for 3 cycles during a trap → outputs held. Flush → branch_taken=0, we=0, opc=NOP.
- Assert iw_rst_n=0 mid-cycle → outputs clear immediately without a clock edge.
